// File: rtl/pixel_pkg.sv
// Shared types and widths for the BRAM pixel streaming path.
package pixel_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stream_state_t;
endpackage

// File: rtl/bram_pixel_streamer_if.sv
// BRAM read port plus valid/ready pixel stream seen by the streamer.
interface bram_pixel_streamer_if #(
  parameter int ADDR_W = pixel_pkg::ADDR_W,
  parameter int DATA_W = pixel_pkg::DATA_W
);
  logic [ADDR_W-1:0] mem_raddr;
  logic              mem_ren;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] px_data;
  logic              px_valid;
  logic              px_ready;

  modport master (
    output mem_raddr, mem_ren, px_data, px_valid,
    input  mem_rdata, px_ready
  );
  modport slave (
    input  mem_raddr, mem_ren, px_data, px_valid,
    output mem_rdata, px_ready
  );
endinterface

// File: rtl/pixel_skid_buf.sv
// Two-entry synchronous FIFO with occupancy and registered head output.
module pixel_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);
  logic [1:0][DATA_W-1:0] r_mem;
  logic                   r_wp;
  logic                   r_rp;
  logic [1:0]             r_occ;
  logic                   w_push;
  logic                   w_pop;

  assign w_pop  = pop && (r_occ != 2'd0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign w_push = push && ((r_occ != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head = r_mem[r_rp];
  assign occ  = r_occ;
endmodule

// File: rtl/bram_pixel_streamer.sv
// Streams a run of BRAM pixels out as valid/ready; define
// BRAM_PIXEL_STREAMER_SWAP_EN to byte-swap each pixel on output.
module bram_pixel_streamer #(
  parameter int ADDR_W = pixel_pkg::ADDR_W,
  parameter int DATA_W = pixel_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     count,
  output logic                busy,
  output logic                done,
  bram_pixel_streamer_if.master bus
);
  import pixel_pkg::*;

  stream_state_t     r_state, w_nstate;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_left;
  logic              r_infl;
  logic              r_zero_done;

  logic              w_ren;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_drain_done;
  logic              w_pop;
  logic              w_credit;
  logic              w_launch;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;

  assign w_pop    = bus.px_valid && bus.px_ready;
  assign w_launch = (r_state == IDLE) && start && (count != '0);
  // The slot vacated by this cycle's handshake counts as free, which is what
  // lets the 2-entry loop sustain one pixel per clock.
  assign w_credit = ({1'b0, w_occ} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});

  always_comb begin
    w_nstate     = r_state;
    w_ren        = 1'b0;
    w_raddr      = r_addr;
    w_drain_done = 1'b0;
    case (r_state)
      IDLE: begin
        // First read goes out in the start cycle, straight from base_addr.
        if (w_launch) begin
          w_ren    = 1'b1;
          w_raddr  = base_addr;
          w_nstate = RUN;
        end
      end
      RUN: begin
        if ((r_left != '0) && w_credit) w_ren = 1'b1;
        if ((r_left == '0) || (w_ren && (r_left == 1))) w_nstate = DRAIN;
      end
      DRAIN: begin
        if ((w_occ == 2'd0) && !r_infl) begin
          w_drain_done = 1'b1;
          w_nstate     = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_infl      <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_nstate;
      r_infl      <= w_ren;
      r_zero_done <= (r_state == IDLE) && start && (count == '0);
      if (w_launch) begin
        r_addr <= base_addr + 1'b1;
        r_left <= count - 1'b1;
      end else if (w_ren) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
    end
  end

  pixel_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_infl),
    .din   (bus.mem_rdata),
    .pop   (w_pop),
    .head  (w_head),
    .occ   (w_occ)
  );

  assign bus.mem_ren   = w_ren;
  assign bus.mem_raddr = w_raddr;
  assign bus.px_valid  = (w_occ != 2'd0);
`ifdef BRAM_PIXEL_STREAMER_SWAP_EN
  assign bus.px_data   = {w_head[DATA_W/2-1:0], w_head[DATA_W-1:DATA_W/2]};
`else
  assign bus.px_data   = w_head;
`endif

  assign done = r_zero_done || w_drain_done;
  assign busy = (r_state != IDLE) && !w_drain_done;
endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Run table plus reset/stall sequences against a BRAM model and pixel scoreboard.
module tb_bram_pixel_streamer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] count = '0;
  logic       busy, done;

  bram_pixel_streamer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  bram_pixel_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    int         cnt;
    int         rmode;   // 0 ready high, 1 fixed toggle pattern, 2 random, 3 ready low
    bit         mid;     // pulse start again while busy
  } run_t;

  logic [15:0] bram [256];
  logic [15:0] sb [$];
  int n_vec = 0, n_err = 0;
  int cyc = 0, rmode = 0, pi = 0;
  int hs_cnt = 0, done_cnt = 0, ren_cnt = 0, last_hs_cyc = 0;
  int occ_m = 0, infl_m = 0;
  bit prev_v = 0, prev_hs = 0;
  logic [15:0] prev_d = '0, last_px = '0;
  bit pat [7] = '{1, 0, 0, 1, 0, 1, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h @cyc %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] expect_px(input logic [15:0] w);
`ifdef BRAM_PIXEL_STREAMER_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // BRAM with 1-cycle registered read
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= bram[bus.mem_raddr];

  initial forever begin @(posedge clk); cyc++; end

  initial begin
    bus.px_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: bus.px_ready = 1'b1;
        1: begin bus.px_ready = pat[pi % 7]; pi++; end
        2: bus.px_ready = 1'($urandom_range(0, 1));
        default: bus.px_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pixel order, stall stability, read credit, done counting.
  initial forever begin
    bit hs;
    @(negedge clk);
    if (!rst_n) begin
      occ_m = 0; infl_m = 0; prev_v = 0; prev_hs = 0;
    end else begin
      hs = bus.px_valid && bus.px_ready;
      if (prev_v && !prev_hs) chk("px_hold", {15'd0, bus.px_valid, bus.px_data}, {15'd0, 1'b1, prev_d});
      if (bus.mem_ren) begin
        ren_cnt++;
        chk("ren_credit", 32'((occ_m + infl_m - int'(hs)) < 2), 32'd1);
      end
      if (hs) begin
        hs_cnt++; last_hs_cyc = cyc; last_px = bus.px_data;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_px got=%0h want=none @cyc %0d", bus.px_data, cyc);
        end else chk("px_data", bus.px_data, sb.pop_front());
      end
      if (done) done_cnt++;
      occ_m  = occ_m + infl_m - int'(hs);
      infl_m = int'(bus.mem_ren);
      prev_v = bus.px_valid; prev_hs = hs; prev_d = bus.px_data;
    end
  end

  task automatic run(input run_t r);
    int t0, tf, hs0, d0, ren0;
    bit got;
    logic [7:0] a;
    for (int i = 0; i < r.cnt; i++) begin
      a = r.base + 8'(i);
      sb.push_back(expect_px(bram[a]));
    end
    hs0 = hs_cnt; d0 = done_cnt; ren0 = ren_cnt; rmode = r.rmode; tf = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = r.base; count = 9'(r.cnt); t0 = cyc;
    @(posedge clk); #1;
    if (r.mid) begin base_addr = 8'h55; count = 9'd3; end
    else start = 1'b0;
    chk("busy_after_start", busy, 32'(r.cnt != 0));
    if (r.mid) begin @(posedge clk); #1 start = 1'b0; end
    if (r.cnt != 0) begin
      got = 0;
      for (int w = 0; w < 20 && !got; w++) begin @(negedge clk); if (bus.px_valid) got = 1; end
      chk("first_valid_lat", got ? 32'(cyc - t0) : 32'hFFFF_FFFF, 32'd2);
      tf = cyc;
    end
    got = 0;
    for (int w = 0; w < 2000 && !got; w++) begin @(negedge clk); if (done) got = 1; end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("done_lat", cyc, (r.cnt == 0) ? t0 + 1 : last_hs_cyc + 1);
      chk("busy_at_done", busy, 32'd0);
    end
    if (r.rmode == 0 && r.cnt != 0) chk("rate", last_hs_cyc - tf, r.cnt - 1);
    repeat (3) @(negedge clk);
    chk("hs_total", hs_cnt - hs0, r.cnt);
    chk("done_once", done_cnt - d0, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    chk("busy_idle", busy, 32'd0);
    if (r.cnt == 0) chk("no_ren", ren_cnt - ren0, 32'd0);
    rmode = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    run_t runs [10];
    int d0;
    runs[0] = '{8'h10, 4,   0, 0};
    runs[1] = '{8'hFE, 4,   0, 0};
    runs[2] = '{8'h40, 4,   1, 0};
    runs[3] = '{8'h00, 0,   0, 0};
    runs[4] = '{8'h00, 256, 0, 0};
    runs[5] = '{8'h80, 6,   0, 1};
    runs[6] = '{8'h30, 1,   0, 0};
    runs[7] = '{8'h90, 37,  2, 0};
    runs[8] = '{8'hF0, 20,  1, 0};
    runs[9] = '{8'h05, 3,   0, 0};
    for (int i = 0; i < 256; i++) bram[i] = 16'hA000 + 16'(i);
    bram[8'h30] = 16'h12AB;

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_ren", bus.mem_ren, 0);  chk("rst_raddr", bus.mem_raddr, 0);
    chk("rst_valid", bus.px_valid, 0); chk("rst_data", bus.px_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run(runs[i]);
      if (i == 6) begin
`ifdef BRAM_PIXEL_STREAMER_SWAP_EN
        chk("swap", last_px, 32'hAB12);
`else
        chk("swap", last_px, 32'h12AB);
`endif
      end
    end

    // Abort a stalled run with reset: outputs clear at once, no done follows.
    rmode = 3; d0 = done_cnt;
    @(posedge clk); #1 start = 1'b1; base_addr = 8'h20; count = 9'd20;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 chk("pre_rst_valid", bus.px_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);          chk("arst_done", done, 0);
    chk("arst_ren", bus.mem_ren, 0);    chk("arst_raddr", bus.mem_raddr, 0);
    chk("arst_valid", bus.px_valid, 0); chk("arst_data", bus.px_data, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);
    rmode = 0;
    run(runs[9]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
